// File: rtl/ccff_io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_io_cfg_sequencer
//  Purpose  : Streams a configuration bitstream into a ccff scan chain while
//             the IOs are isolated, and reads back the previous chain contents
//             from the chain tail as the new bits are shifted in.
//  Ports    : prog_clk/prog_rst_n   - clock, async active-low reset
//             cfg_start/cfg_abort   - begin / abandon a programming sequence
//             cfg_data/valid/ready  - bitstream words, MSB shifted first
//             ccff_head/shift_en    - serial data and enable to the chain
//             ccff_tail             - serial data from the chain tail
//             IO_ISOL_N             - 0 = IOs isolated
//             rb_data/rb_valid      - readback words of old chain contents
//             cfg_busy/done/err     - status (err is a sticky abort flag)
//  Revision : 1.0 - initial release
// ============================================================================
module ccff_io_cfg_sequencer #(
    parameter int CHAIN_LEN  = 16,
    parameter int WORD_W     = 8,
    parameter int ISO_CYC    = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int c_BL_W    = $clog2(CHAIN_LEN + 1);
    localparam int c_CNT_W   = $clog2(WORD_W + 1);
    localparam int c_CYC_MAX = (ISO_CYC > SETTLE_CYC) ? ISO_CYC : SETTLE_CYC;
    localparam int c_CYC_W   = (c_CYC_MAX > 1) ? $clog2(c_CYC_MAX) : 1;

    localparam logic [c_BL_W-1:0]  c_CHAIN_LEN   = c_BL_W'(CHAIN_LEN);
    localparam logic [c_BL_W-1:0]  c_BL_ONE      = c_BL_W'(1);
    localparam logic [c_CNT_W-1:0] c_WORD_W      = c_CNT_W'(WORD_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_RB_LAST     = c_CNT_W'(WORD_W - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE     = c_CYC_W'(1);
    localparam logic [c_CYC_W-1:0] c_ISO_LAST    = c_CYC_W'(ISO_CYC - 1);
    localparam logic [c_CYC_W-1:0] c_SETTLE_LAST = c_CYC_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISOLATE = 3'd1,
        S_SHIFT   = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               r_next;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [c_BL_W-1:0]    r_bits_left;
    logic [WORD_W-1:0]    r_buf;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WORD_W-2:0]    r_rb_sh;      // readback samples gathered so far, right-aligned
    logic [c_CNT_W-1:0]   r_rb_cnt;
    logic                 r_err;

    logic                 w_busy;
    logic                 w_shift;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_abort;
    logic                 w_start;
    logic                 w_rb_fire;
    logic [WORD_W-1:0]    w_rb_word;
    logic [c_CNT_W-1:0]   w_load_cnt;

    assign w_busy    = (r_state == S_ISOLATE) || (r_state == S_SHIFT) || (r_state == S_SETTLE);
    assign w_shift   = (r_state == S_SHIFT) && (r_cnt != '0);
    assign w_ready   = (r_state == S_SHIFT) && (r_cnt == '0) && (r_bits_left != '0);
    assign w_accept  = w_ready && cfg_valid;
    assign w_abort   = cfg_abort && w_busy;
    assign w_start   = cfg_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rb_word = {r_rb_sh, ccff_tail};
    // A readback word closes on its WORD_W-th sample or on the last chain bit.
    assign w_rb_fire = w_shift && ((r_rb_cnt == c_RB_LAST) || (r_bits_left == c_BL_ONE));

    // The final word only carries the bits still owed to the chain.
    always_comb begin
        w_load_cnt = c_WORD_W;
        if (int'(r_bits_left) < WORD_W) begin
            w_load_cnt = c_CNT_W'(r_bits_left);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next        = r_state;
        cfg_ready     = w_ready;
        ccff_shift_en = w_shift;
        ccff_head     = w_shift & r_buf[WORD_W-1];
        rb_valid      = w_rb_fire;
        // Partial final word is left-aligned; idle value is zero.
        rb_data       = w_rb_fire ? (w_rb_word << (c_RB_LAST - r_rb_cnt)) : '0;
        IO_ISOL_N     = (r_state == S_DONE);
        cfg_busy      = w_busy;
        cfg_done      = (r_state == S_DONE);
        cfg_err       = r_err;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (cfg_start) r_next = S_ISOLATE;
            end
            S_ISOLATE: begin
                if (r_cyc == c_ISO_LAST) r_next = S_SHIFT;
            end
            S_SHIFT: begin
                if ((w_shift && (r_bits_left == c_BL_ONE)) || (r_bits_left == '0)) begin
                    r_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cyc == c_SETTLE_LAST) r_next = S_DONE;
            end
            default: r_next = S_IDLE;
        endcase

        if (w_abort) r_next = S_IDLE;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_cyc       <= '0;
            r_bits_left <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_rb_sh     <= '0;
            r_rb_cnt    <= '0;
            r_err       <= 1'b0;
        end else if (w_abort) begin
            r_cyc       <= '0;
            r_bits_left <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_rb_sh     <= '0;
            r_rb_cnt    <= '0;
            r_err       <= 1'b1;
        end else begin
            if (r_next != r_state) begin
                r_cyc <= '0;
            end else if ((r_state == S_ISOLATE) || (r_state == S_SETTLE)) begin
                r_cyc <= r_cyc + c_CYC_ONE;
            end

            if (w_start) begin
                r_err       <= 1'b0;
                r_bits_left <= c_CHAIN_LEN;
                r_buf       <= '0;
                r_cnt       <= '0;
                r_rb_sh     <= '0;
                r_rb_cnt    <= '0;
            end else if (w_accept) begin
                r_buf <= cfg_data;
                r_cnt <= w_load_cnt;
            end else if (w_shift) begin
                r_buf       <= {r_buf[WORD_W-2:0], 1'b0};
                r_cnt       <= r_cnt - c_CNT_ONE;
                r_bits_left <= r_bits_left - c_BL_ONE;
                if (w_rb_fire) begin
                    r_rb_sh  <= '0;
                    r_rb_cnt <= '0;
                end else begin
                    r_rb_sh  <= w_rb_word[WORD_W-2:0];
                    r_rb_cnt <= r_rb_cnt + c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccff_io_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccff_io_cfg_sequencer
//  Purpose  : Directed bench for ccff_io_cfg_sequencer. Two instances: a
//             16-bit chain and a 12-bit chain, each with a behavioural chain
//             model attached to head/tail.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ccff_io_cfg_sequencer;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       prog_rst_n;
    logic       sel;            // 0 = 16-bit instance, 1 = 12-bit instance
    logic       start, abort, valid;
    logic [7:0] data;

    logic       ready_a, head_a, sh_a, iso_a, rbv_a, busy_a, done_a, err_a, tail_a;
    logic [7:0] rb_a;
    logic       ready_b, head_b, sh_b, iso_b, rbv_b, busy_b, done_b, err_b, tail_b;
    logic [7:0] rb_b;

    ccff_io_cfg_sequencer #(.CHAIN_LEN(16), .WORD_W(8), .ISO_CYC(4), .SETTLE_CYC(4)) u_dut_a (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n),
        .cfg_start(start & ~sel), .cfg_abort(abort & ~sel),
        .cfg_data(data), .cfg_valid(valid & ~sel), .cfg_ready(ready_a),
        .ccff_head(head_a), .ccff_shift_en(sh_a), .ccff_tail(tail_a),
        .IO_ISOL_N(iso_a), .rb_data(rb_a), .rb_valid(rbv_a),
        .cfg_busy(busy_a), .cfg_done(done_a), .cfg_err(err_a));

    ccff_io_cfg_sequencer #(.CHAIN_LEN(12), .WORD_W(8), .ISO_CYC(4), .SETTLE_CYC(4)) u_dut_b (
        .prog_clk(prog_clk), .prog_rst_n(prog_rst_n),
        .cfg_start(start & sel), .cfg_abort(abort & sel),
        .cfg_data(data), .cfg_valid(valid & sel), .cfg_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(sh_b), .ccff_tail(tail_b),
        .IO_ISOL_N(iso_b), .rb_data(rb_b), .rb_valid(rbv_b),
        .cfg_busy(busy_b), .cfg_done(done_b), .cfg_err(err_b));

    // Chain models: head enters bit 0, tail is the top bit.
    logic        pre_ld;
    logic [15:0] pre_a, chain_a;
    logic [11:0] pre_b, chain_b;
    always @(posedge prog_clk) begin
        if (pre_ld) begin
            chain_a <= pre_a;
            chain_b <= pre_b;
        end else begin
            if (sh_a) chain_a <= {chain_a[14:0], head_a};
            if (sh_b) chain_b <= {chain_b[10:0], head_b};
        end
    end
    assign tail_a = chain_a[15];
    assign tail_b = chain_b[11];

    logic       m_ready, m_head, m_sh, m_iso, m_rbv, m_busy, m_done, m_err;
    logic [7:0] m_rb;
    assign m_ready = sel ? ready_b : ready_a;
    assign m_head  = sel ? head_b  : head_a;
    assign m_sh    = sel ? sh_b    : sh_a;
    assign m_iso   = sel ? iso_b   : iso_a;
    assign m_rbv   = sel ? rbv_b   : rbv_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_rb    = sel ? rb_b    : rb_a;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of one load sequence
    int          iso_n, n_sh, first_sh, last_sh, done_c, n_rb, iso_bad;
    logic [31:0] heads;
    logic [7:0]  rbw0, rbw1;

    task automatic preload(input logic [15:0] va, input logic [11:0] vb);
        pre_a = va; pre_b = vb; pre_ld = 1'b1;
        @(negedge prog_clk);
        pre_ld = 1'b0;
    endtask

    // Starts a sequence on the selected instance, feeds two words (with an
    // optional input gap before the second) and records what the chain saw.
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap_cyc);
        int widx;
        int gap_ctr;
        widx = 0; gap_ctr = 0; n_sh = 0; first_sh = -1; last_sh = -1; done_c = -1;
        n_rb = 0; iso_bad = 0; heads = '0; rbw0 = '0; rbw1 = '0; iso_n = 0;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        while (m_busy && !m_ready && iso_n < 50) begin
            if (m_iso) iso_bad++;
            iso_n++;
            @(negedge prog_clk);
        end
        for (int c = 0; c < 200; c++) begin
            if (m_sh) begin
                n_sh++;
                heads = {heads[30:0], m_head};
                if (first_sh < 0) first_sh = c;
                last_sh = c;
            end
            if (m_rbv) begin
                if (n_rb == 0) rbw0 = m_rb; else rbw1 = m_rb;
                n_rb++;
            end
            if (!m_busy) begin
                done_c = c;
                break;
            end
            if (m_iso) iso_bad++;
            valid = 1'b0;
            if (m_ready && widx < 2) begin
                if (widx == 1 && gap_ctr < gap_cyc) begin
                    gap_ctr++;
                end else begin
                    valid = 1'b1;
                    data  = (widx == 0) ? w0 : w1;
                    widx++;
                end
            end
            @(negedge prog_clk);
        end
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        prog_rst_n = 1'b0; sel = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
        data = 8'h00; pre_ld = 1'b0; pre_a = 16'h0; pre_b = 12'h0;
        repeat (3) @(negedge prog_clk);
        chk("rst_iso",   iso_a,   0);
        chk("rst_busy",  busy_a,  0);
        chk("rst_done",  done_a,  0);
        chk("rst_err",   err_a,   0);
        chk("rst_ready", ready_a, 0);
        chk("rst_shen",  sh_a,    0);
        chk("rst_head",  head_a,  0);
        chk("rst_rbv",   rbv_a,   0);
        chk("rst_rb",    rb_a,    0);
        prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);

        // Abort while idle is ignored
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("idle_abort_err",  err_a,  0);
        chk("idle_abort_busy", busy_a, 0);

        // Nominal 16-bit load
        preload(16'hFFFF, 12'h000);
        run_load(8'hA5, 8'h3C, 0);
        chk("nom_iso_cycles", iso_n, 4);
        chk("nom_iso_low",    iso_bad, 0);
        chk("nom_nshift",     n_sh, 16);
        chk("nom_heads",      heads[15:0], 16'hA53C);
        chk("nom_bubbles",    last_sh - first_sh + 1 - n_sh, 1);
        chk("nom_nrb",        n_rb, 2);
        chk("nom_rb0",        rbw0, 8'hFF);
        chk("nom_rb1",        rbw1, 8'hFF);
        chk("nom_settle",     done_c - last_sh - 1, 4);
        chk("nom_done",       m_done, 1);
        chk("nom_iso_hi",     m_iso, 1);
        chk("nom_chain",      chain_a, 16'hA53C);

        // Abort alone in DONE is ignored
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("done_abort_done", done_a, 1);
        chk("done_abort_err",  err_a,  0);

        // Start + abort in DONE: start wins
        start = 1'b1; abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0;
        chk("done_sa_busy", busy_a, 1);
        chk("done_sa_err",  err_a,  0);
        chk("done_sa_iso",  iso_a,  0);
        for (int i = 0; i < 20 && !ready_a; i++) @(negedge prog_clk);
        chk("sa_reach_shift", ready_a, 1);
        // Start + abort in SHIFT: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0;
        chk("shift_sa_busy", busy_a, 0);
        chk("shift_sa_err",  err_a,  1);
        chk("shift_sa_done", done_a, 0);

        // Partial final word on the 12-bit chain
        sel = 1'b1;
        preload(16'h0000, 12'hABC);
        run_load(8'hA5, 8'hF0, 0);
        chk("part_nshift", n_sh, 12);
        chk("part_heads",  heads[11:0], 12'hA5F);
        chk("part_nrb",    n_rb, 2);
        chk("part_rb0",    rbw0, 8'hAB);
        chk("part_rb1",    rbw1, 8'hC0);
        chk("part_settle", done_c - last_sh - 1, 4);
        chk("part_done",   m_done, 1);
        chk("part_chain",  chain_b, 12'hA5F);
        sel = 1'b0;

        // Input underrun of 5 cycles between words
        preload(16'h1234, 12'h000);
        run_load(8'hA5, 8'h3C, 5);
        chk("und_nshift",  n_sh, 16);
        chk("und_bubbles", last_sh - first_sh + 1 - n_sh, 6);
        chk("und_heads",   heads[15:0], 16'hA53C);
        chk("und_rb0",     rbw0, 8'h12);
        chk("und_rb1",     rbw1, 8'h34);
        chk("und_chain",   chain_a, 16'hA53C);
        chk("und_done",    done_a, 1);

        // Abort in SHIFT after 5 bits
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !ready_a; i++) @(negedge prog_clk);
        valid = 1'b1; data = 8'hA5;
        @(negedge prog_clk);
        valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 5; i++) begin
            if (sh_a) cnt++;
            if (cnt < 5) @(negedge prog_clk);
        end
        chk("abt_five_bits", cnt, 5);
        @(negedge prog_clk);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("abt_busy",  busy_a,  0);
        chk("abt_err",   err_a,   1);
        chk("abt_iso",   iso_a,   0);
        chk("abt_shen",  sh_a,    0);
        chk("abt_ready", ready_a, 0);
        repeat (3) @(negedge prog_clk);
        chk("abt_hold_err", err_a, 1);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("abt_restart_err",  err_a,  0);
        chk("abt_restart_busy", busy_a, 1);

        // Asynchronous reset pulse mid-SHIFT
        for (int i = 0; i < 20 && !ready_a; i++) @(negedge prog_clk);
        valid = 1'b1; data = 8'hA5;
        @(negedge prog_clk);
        valid = 1'b0;
        @(negedge prog_clk);
        chk("ar_pre_shen", sh_a, 1);
        #2 prog_rst_n = 1'b0;
        #1;
        chk("ar_shen",  sh_a,    0);
        chk("ar_busy",  busy_a,  0);
        chk("ar_iso",   iso_a,   0);
        chk("ar_ready", ready_a, 0);
        chk("ar_head",  head_a,  0);
        chk("ar_rbv",   rbv_a,   0);
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge prog_clk);
            if (sh_a || busy_a || iso_a) cnt++;
        end
        chk("ar_quiet_after", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccff_io_cfg_sequencer.md
CCFF_IO_CFG_SEQUENCER -- requirements
Module: ccff_io_cfg_sequencer

Interface
REQ-001 Parameters SHALL be CHAIN_LEN (default 16): number of configuration flip-flops in the ccff chain; WORD_W (default 8): width of one bitstream word; ISO_CYC (default 4): isolation setup cycles; SETTLE_CYC (default 4): settle cycles after the last shift.
REQ-002 The ports SHALL be, in order:
- prog_clk  in  1  the single clock; all state changes on its rising edge.
- prog_rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to begin programming.
- cfg_abort  in  1  one-cycle request to abandon programming.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  out  1  serial bit to the chain head.
- ccff_shift_en  out  1  chain clock enable; the chain advances on every prog_clk edge where this is 1.
- ccff_tail  in  1  serial bit from the chain tail.
- IO_ISOL_N  out  1  IO isolation; 0 = isolated.
- rb_data  out  WORD_W  readback word of the previous chain contents.
- rb_valid  out  1  one-cycle strobe qualifying rb_data.
- cfg_busy  out  1  high in ISOLATE, SHIFT and SETTLE.
- cfg_done  out  1  high in DONE.
- cfg_err  out  1  sticky abort flag.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, ISOLATE, SHIFT, SETTLE and DONE.
REQ-004 In IDLE or DONE, cfg_start SHALL cause a transition to ISOLATE, clear cfg_err and load bits_left with CHAIN_LEN.
REQ-005 cfg_start SHALL be ignored in ISOLATE, SHIFT and SETTLE.
REQ-006 ISOLATE SHALL drive IO_ISOL_N=0 and last exactly ISO_CYC cycles, then go to SHIFT.
REQ-007 In SHIFT, cfg_ready SHALL be 1 only while the word buffer is empty and bits_left>0; a handshake SHALL load cfg_data into the buffer with count=min(WORD_W, bits_left).
REQ-008 On every cycle where the buffer holds at least one bit:
- ccff_shift_en=1;
- ccff_head=buffer MSB;
- the buffer shifts left by one;
- count and bits_left decrement.
REQ-009 ccff_shift_en SHALL be 0 while the buffer is empty, so an input underrun stalls the chain without corrupting it.
REQ-010 Each word SHALL cost one bubble cycle; a word of N bits occupies the chain for N cycles after acceptance.
REQ-011 When CHAIN_LEN is not a multiple of WORD_W, the final word SHALL contribute only its upper bits_left bits, and its low bits SHALL be discarded.
REQ-012 On each ccff_shift_en cycle, ccff_tail SHALL be sampled and shifted MSB-first into the readback register.
REQ-013 rb_valid SHALL pulse for one cycle, with rb_data, after each WORD_W samples and after the final sample.
REQ-014 A final partial readback word SHALL be left-aligned, with its low bits 0.
REQ-015 When bits_left reaches 0, the FSM SHALL go to SETTLE, hold ccff_shift_en=0 and IO_ISOL_N=0 for SETTLE_CYC cycles, then go to DONE.
REQ-016 DONE SHALL drive IO_ISOL_N=1 and cfg_done=1 until the next cfg_start.
REQ-017 cfg_abort in ISOLATE, SHIFT or SETTLE SHALL, at the next edge:
- go to IDLE;
- set cfg_err=1;
- flush the buffer and the readback state;
- keep IO_ISOL_N=0.
REQ-018 cfg_abort in IDLE or DONE SHALL be ignored.
REQ-019 If cfg_abort and cfg_start are asserted in the same cycle, cfg_abort SHALL take priority.
REQ-020 In every state other than SHIFT, cfg_ready, ccff_shift_en and rb_valid SHALL be 0.

Reset
REQ-021 While prog_rst_n=0, the block SHALL asynchronously force:
- state IDLE;
- IO_ISOL_N=0;
- ccff_head=0, ccff_shift_en=0, cfg_ready=0;
- rb_data=0, rb_valid=0;
- cfg_busy=0, cfg_done=0, cfg_err=0;
- all counters and buffers cleared.
REQ-022 Reset assertion mid-programming SHALL drop ccff_shift_en in the same cycle and SHALL leave IO_ISOL_N=0 until a full sequence completes.
REQ-023 Release of prog_rst_n SHALL take effect on the first prog_clk edge after deassertion.

Verification
REQ-024 Nominal load (CHAIN_LEN=16, WORD_W=8): words 0xA5, 0x3C with the chain preloaded 0xFFFF -> ccff_head sequence 1010010100111100; 16 shift cycles; rb_data 0xFF twice; IO_ISOL_N rises 4 cycles after the last shift.
REQ-025 Partial word (CHAIN_LEN=12): words 0xA5, 0xF0 -> 12 shift cycles; the second rb_data is left-aligned with its low 4 bits 0; cfg_done=1.
REQ-026 Underrun: cfg_valid low for 5 cycles between words -> ccff_shift_en low for exactly those cycles; final chain contents equal the nominal case.
REQ-027 Abort in SHIFT after 5 bits -> next cycle IDLE, cfg_err=1, IO_ISOL_N=0; a later cfg_start clears cfg_err.
REQ-028 Simultaneous cfg_start and cfg_abort in DONE -> the abort is ignored and ISOLATE is entered; in SHIFT -> IDLE.
REQ-029 Async reset pulse mid-SHIFT between clock edges -> outputs take their reset values immediately; no further ccff_shift_en until a new cfg_start.
